// File: rtl/count_arbiter.sv
// count_arbiter -- two-requester round-robin owner of a shared up-counter.
//
// A requester holds req[i] high for the whole run. The winner's run length
// is latched at grant, the counter runs 1..len, and a one-cycle done pulse
// (with done_id, plus abort if the run was cut short) closes the run.
//
// Ports:
//   clk      clock, all state changes on posedge
//   reset    asynchronous, active-high
//   req      [1:0] per-requester run request
//   len0     [WIDTH-1:0] run length for requester 0 (sampled at grant)
//   len1     [WIDTH-1:0] run length for requester 1 (sampled at grant)
//   pause    freezes the counter while in COUNT (only with COUNT_ARB_PAUSE_EN)
//   grant    [1:0] one-hot current owner, 2'b00 when none
//   count    [WIDTH-1:0] shared counter value
//   busy     high in GRANT and COUNT
//   done     one-cycle pulse at the end of every run
//   done_id  requester the done pulse belongs to
//   abort    high with done when the owner dropped req early
//
// Optional feature macro: COUNT_ARB_PAUSE_EN (adds the pause input).

module count_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
`ifdef COUNT_ARB_PAUSE_EN
    input  logic             pause,
`endif
    output logic [1:0]       grant,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             abort
);

    typedef enum logic [1:0] {IDLE, GRANT, COUNT, DONE} state_t;

    state_t           state;
    logic             owner;     // latched winner of the current run
    logic             last;      // last-served requester
    logic [WIDTH-1:0] run_len;   // latched length of the current run
    logic             pause_i;
    logic             win;

`ifdef COUNT_ARB_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    // On contention the requester not served last wins; otherwise the single
    // requesting bit decides (req[1] high alone means requester 1).
    always_comb begin
        win = req[1];
        if (req == 2'b11)
            win = ~last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            run_len <= '0;
            grant   <= 2'b00;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            abort   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    abort <= 1'b0;
                    if (|req) begin
                        state   <= GRANT;
                        owner   <= win;
                        run_len <= win ? len1 : len0;
                        count   <= '0;
                        grant   <= win ? 2'b10 : 2'b01;
                        busy    <= 1'b1;
                    end
                end

                GRANT: begin
                    if (!req[owner] || run_len == '0) begin
                        // Owner gone (abort) or nothing to count.
                        state   <= DONE;
                        grant   <= 2'b00;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        done_id <= owner;
                        abort   <= ~req[owner];
                    end else begin
                        state <= COUNT;
                        count <= {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                end

                COUNT: begin
                    // Abort outranks pause; pause outranks completion, so a
                    // paused run sitting at len stays in COUNT.
                    if (!req[owner]) begin
                        state   <= DONE;
                        grant   <= 2'b00;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        done_id <= owner;
                        abort   <= 1'b1;
                    end else if (!pause_i) begin
                        if (count == run_len) begin
                            state   <= DONE;
                            grant   <= 2'b00;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            done_id <= owner;
                            abort   <= 1'b0;
                        end else begin
                            // count < run_len here, so this never wraps.
                            count <= count + 1'b1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    abort <= 1'b0;
                    last  <= owner;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_arbiter.sv
// tb_count_arbiter -- self-checking bench for count_arbiter.
//
// The reference model tracks a run as arithmetic: k = cycles since the grant
// edge, p = cycles spent paused. Expected count is k-p, and the run completes
// on the edge where k-p would reach len+1. Directed scenarios are followed by
// a randomized soak against the same model.

module tb_count_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req;
    logic [W-1:0] len0, len1;
    logic         pause;
    logic [1:0]   grant;
    logic [W-1:0] count;
    logic         busy, done, done_id, abort;

    int vectors = 0;
    int errors  = 0;

    count_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .len0    (len0),
        .len1    (len1),
`ifdef COUNT_ARB_PAUSE_EN
        .pause   (pause),
`endif
        .grant   (grant),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .abort   (abort)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int   m_run;     // 0 no run, 1 run active, 2 done cycle
    int   m_k, m_p, m_n, m_cnt;
    logic m_own, m_last;
    logic e_done, e_abort;

    task automatic model_reset();
        m_run = 0; m_k = 0; m_p = 0; m_n = 0; m_cnt = 0;
        m_own = 1'b0; m_last = 1'b1; e_done = 1'b0; e_abort = 1'b0;
    endtask

    task automatic model_step();
        logic pz;
        pz = 1'b0;
`ifdef COUNT_ARB_PAUSE_EN
        pz = pause;
`endif
        e_done = 1'b0;
        e_abort = 1'b0;
        case (m_run)
            2: begin m_run = 0; m_last = m_own; end
            0: if (req != 2'b00) begin
                m_own = (req == 2'b11) ? ~m_last : req[1];
                m_n   = m_own ? int'(len1) : int'(len0);
                m_k = 0; m_p = 0; m_cnt = 0; m_run = 1;
            end
            default: begin
                if (!req[m_own]) begin
                    m_run = 2; e_done = 1'b1; e_abort = 1'b1;
                end else begin
                    if (m_k >= 1 && pz) m_p++;
                    m_k++;
                    if (m_k - m_p == m_n + 1) begin
                        m_run = 2; e_done = 1'b1;
                    end else begin
                        m_cnt = m_k - m_p;
                    end
                end
            end
        endcase
    endtask

    function automatic logic [W+4:0] exp_vec();
        logic [1:0] g;
        g = (m_run == 1) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
        return {g, W'(m_cnt), (m_run == 1), e_done, e_abort};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic go_idle();
        req = 2'b00;
        tick();
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; req = 2'b00; len0 = '0; len1 = '0; pause = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        vectors++;
        if ({grant, count, busy, done, done_id, abort} !== {2'b00, W'(0), 4'b0000}) begin
            errors++;
            $display("FAIL reset: got %b expected all zero", {grant, count, busy, done, done_id, abort});
        end
        reset = 1'b0;
    endtask

    task automatic test_single_run();
        int done_cyc;
        done_cyc = -1;
        req = 2'b01; len0 = 8'd3; len1 = 8'd9;
        for (int c = 1; c <= 6; c++) begin
            tick();
            len0 = 8'd7;  // must not affect the latched length
            vectors++;
            if ({grant, count, busy, done, abort} !== exp_vec()) begin
                errors++;
                $display("FAIL single_run edge %0d: got %b expected %b", c, {grant, count, busy, done, abort}, exp_vec());
            end
            if (done && done_cyc < 0) done_cyc = c;
            if (done) req = 2'b00;
        end
        vectors++;
        if (done_cyc != 5) begin
            errors++;
            $display("FAIL single_run_done_edge: got %0d expected 5", done_cyc);
        end
        go_idle();
    endtask

    task automatic test_contention();
        int dcyc[$];
        logic did[$];
        apply_reset();
        req = 2'b11; len0 = 8'd2; len1 = 8'd2;
        for (int c = 1; c <= 16; c++) begin
            tick();
            vectors++;
            if ({grant, count, busy, done, abort} !== exp_vec()) begin
                errors++;
                $display("FAIL contention edge %0d: got %b expected %b", c, {grant, count, busy, done, abort}, exp_vec());
            end
            if (done) begin dcyc.push_back(c); did.push_back(done_id); end
        end
        vectors++;
        if (dcyc.size() < 3) begin
            errors++;
            $display("FAIL contention_runs: got %0d done pulses expected 3", dcyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (did[i] !== logic'(i % 2)) begin
                    errors++;
                    $display("FAIL contention_id run %0d: got %b expected %0d", i, did[i], i % 2);
                end
            end
            // Run turnaround is N+3 cycles: GRANT, N counts, DONE, IDLE.
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (dcyc[i] - dcyc[i-1] != 2 + 3) begin
                    errors++;
                    $display("FAIL contention_spacing %0d: got %0d expected 5", i, dcyc[i] - dcyc[i-1]);
                end
            end
        end
        go_idle();
        tick();
    endtask

    task automatic test_zero_len();
        req = 2'b10; len1 = 8'd0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            vectors++;
            if ({grant, count, busy, done, abort} !== exp_vec() || (e_done && done_id !== 1'b1)) begin
                errors++;
                $display("FAIL zero_len edge %0d: got %b id %b expected %b", c, {grant, count, busy, done, abort}, done_id, exp_vec());
            end
        end
        vectors++;
        if (!(m_run == 0 && e_done == 1'b0 && m_own == 1'b1)) begin
            errors++;
            $display("FAIL zero_len_model_state: run %0d own %b", m_run, m_own);
        end
        go_idle();
    endtask

    task automatic test_abort();
        int guard;
        req = 2'b01; len0 = 8'd10;
        guard = 0;
        do begin tick(); guard++; end while (count !== 8'd4 && guard < 30);
        vectors++;
        if (guard >= 30) begin
            errors++;
            $display("FAIL abort_timeout: count %0d never reached 4", count);
        end
        req = 2'b00;
        tick();
        vectors++;
        if ({done, abort, count, done_id} !== {1'b1, 1'b1, 8'd4, 1'b0} || {grant, count, busy, done, abort} !== exp_vec()) begin
            errors++;
            $display("FAIL abort: got done %b abort %b count %0d id %b", done, abort, count, done_id);
        end
        go_idle();
    endtask

    task automatic test_reset_midrun();
        int guard;
        req = 2'b01; len0 = 8'd200;
        guard = 0;
        do begin tick(); guard++; end while (count !== 8'd50 && guard < 80);
        vectors++;
        if (guard >= 80) begin
            errors++;
            $display("FAIL reset_mid_timeout: count %0d never reached 50", count);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({grant, count, busy, done, done_id, abort} !== {2'b00, W'(0), 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid_async: got %b expected all zero", {grant, count, busy, done, done_id, abort});
        end
        model_reset();
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b0 || count !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_hold: got done %b count %0d expected 0 0", done, count);
        end
        reset = 1'b0;
        req = 2'b11; len0 = 8'd1; len1 = 8'd1;
        tick();
        vectors++;
        if (grant !== 2'b01 || {grant, count, busy, done, abort} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid_regrant: got grant %b expected 01", grant);
        end
        req = 2'b01;
        for (int c = 0; c < 4; c++) tick();
        go_idle();
    endtask

    task automatic test_max_len();
        int guard;
        req = 2'b01; len0 = 8'hFF;
        guard = 0;
        do begin
            tick(); guard++;
            vectors++;
            if ({grant, count, busy, done, abort} !== exp_vec()) begin
                errors++;
                $display("FAIL max_len cycle %0d: got %b expected %b", guard, {grant, count, busy, done, abort}, exp_vec());
            end
        end while (done !== 1'b1 && guard < 300);
        vectors++;
        if (count !== 8'hFF || guard != 257) begin
            errors++;
            $display("FAIL max_len_end: got count %0d at edge %0d expected 255 at edge 257", count, guard);
        end
        go_idle();
    endtask

`ifdef COUNT_ARB_PAUSE_EN
    task automatic test_pause();
        int c;
        req = 2'b01; len0 = 8'd5;
        c = 0;
        do begin tick(); c++; end while (count !== 8'd2 && c < 20);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); c++;
            vectors++;
            if (count !== 8'd2 || {grant, count, busy, done, abort} !== exp_vec()) begin
                errors++;
                $display("FAIL pause_hold %0d: got count %0d expected 2", i, count);
            end
        end
        pause = 1'b0;
        do begin tick(); c++; end while (done !== 1'b1 && c < 30);
        // Unpaused done arrives at edge len+2 = 7; three held cycles delay it.
        vectors++;
        if (c != 10 || count !== 8'd5) begin
            errors++;
            $display("FAIL pause_done: got edge %0d count %0d expected edge 10 count 5", c, count);
        end
        go_idle();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                len0 = ($urandom_range(0, 49) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0)
                len1 = ($urandom_range(0, 49) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
            pause = ($urandom_range(0, 3) == 0);
            tick();
            vectors++;
            if ({grant, count, busy, done, abort} !== exp_vec() || (e_done && done_id !== m_own)) begin
                errors++;
                $display("FAIL random cycle %0d: got %b id %b expected %b id %b", c, {grant, count, busy, done, abort}, done_id, exp_vec(), m_own);
            end
        end
        pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_contention();
        test_zero_len();
        test_abort();
        test_reset_midrun();
        test_max_len();
`ifdef COUNT_ARB_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
